// File: rtl/axi_crossbar_wr_route.sv
// Purpose : per-slave W router; steers each W burst to the master picked by its write command, sinks DECERR bursts and answers them with a B response.
// Latency : 0 cycles master-side W (pass-through); 1 cycle when AXI_CROSSBAR_WR_ROUTE_OUTPUT_REG_EN is defined (2-entry skid).
// Backpres: s_axi_wready follows the selected m_axi_wready (or skid-not-full); commands stall outside IDLE; B waits on m_decerr_bready.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   s_wc_select/decerr/id/valid/ready   write command from the address decode stage
//   s_axi_w*                        slave-side W channel
//   m_axi_w* (wvalid/wready per master) shared master-side W data, one-hot valid
//   m_decerr_b*                     locally generated DECERR write response
// Optional build macro: AXI_CROSSBAR_WR_ROUTE_OUTPUT_REG_EN (registered master-side W outputs).

module axi_crossbar_wr_route #(
  parameter int M_COUNT    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int CL_M_COUNT = (M_COUNT > 1) ? $clog2(M_COUNT) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CL_M_COUNT-1:0] s_wc_select,
  input  logic                  s_wc_decerr,
  input  logic [ID_WIDTH-1:0]   s_wc_id,
  input  logic                  s_wc_valid,
  output logic                  s_wc_ready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic [M_COUNT-1:0]    m_axi_wvalid,
  input  logic [M_COUNT-1:0]    m_axi_wready,
  output logic [ID_WIDTH-1:0]   m_decerr_bid,
  output logic [1:0]            m_decerr_bresp,
  output logic                  m_decerr_bvalid,
  input  logic                  m_decerr_bready
);

  typedef enum logic [1:0] {IDLE, ROUTE, SINK, RESP} state_t;

  state_t                state, state_nxt;
  logic [CL_M_COUNT-1:0] sel_reg;
  logic [ID_WIDTH-1:0]   id_reg;
  logic [8:0]            beat_cnt;

  logic sel_ok;     // latched select addresses a real master
  logic route_rdy;  // downstream can take a beat while routing
  logic cmd_acc;
  logic beat_acc;
  logic beat_last;

  assign sel_ok    = int'(sel_reg) < M_COUNT;
  assign cmd_acc   = s_wc_valid && (state == IDLE);
  assign beat_acc  = s_axi_wvalid && s_axi_wready;
  // Runaway bursts: the 257th beat closes the burst even without wlast.
  assign beat_last = s_axi_wlast || (beat_cnt == 9'd256);

  assign s_wc_ready      = (state == IDLE);
  // An out-of-range select degrades to a silent sink so the burst cannot hang.
  assign s_axi_wready    = (state == SINK) || ((state == ROUTE) && (!sel_ok || route_rdy));
  assign m_decerr_bvalid = (state == RESP);
  assign m_decerr_bid    = id_reg;
  assign m_decerr_bresp  = 2'b11;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (cmd_acc) state_nxt = s_wc_decerr ? SINK : ROUTE;
      ROUTE: if (beat_acc && beat_last) state_nxt = IDLE;
      SINK:  if (beat_acc && beat_last) state_nxt = RESP;
      RESP:  if (m_decerr_bready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel_reg  <= '0;
      id_reg   <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (cmd_acc) begin
        sel_reg  <= s_wc_select;
        id_reg   <= s_wc_id;
        beat_cnt <= '0;
      end else if (beat_acc && (beat_cnt != 9'd256)) begin
        beat_cnt <= beat_cnt + 9'd1;
      end
    end
  end

`ifdef AXI_CROSSBAR_WR_ROUTE_OUTPUT_REG_EN
  // Two-entry skid; each entry remembers its own master so a finished burst can
  // drain while the next command already routes elsewhere.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
    logic                  last;
    logic [CL_M_COUNT-1:0] sel;
  } skid_t;

  skid_t      skid_q [2];
  skid_t      head;
  logic       wr_ptr, rd_ptr;
  logic [1:0] count;
  logic       push, pop;

  assign head      = skid_q[rd_ptr];
  assign route_rdy = (count != 2'd2);
  assign push      = (state == ROUTE) && sel_ok && s_axi_wvalid && route_rdy;
  assign pop       = (count != 2'd0) && m_axi_wready[head.sel];

  assign m_axi_wdata = head.data;
  assign m_axi_wstrb = head.strb;
  assign m_axi_wlast = head.last;

  always_comb begin
    m_axi_wvalid = '0;
    if (count != 2'd0) m_axi_wvalid[head.sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Payload needs no reset: entries are only observed when counted valid.
  always_ff @(posedge clk) begin
    if (push) skid_q[wr_ptr] <= '{data: s_axi_wdata, strb: s_axi_wstrb,
                                  last: beat_last, sel: sel_reg};
  end
`else
  logic [M_COUNT-1:0] sel_onehot;

  always_comb begin
    sel_onehot = '0;
    if (sel_ok) sel_onehot[sel_reg] = 1'b1;
  end

  assign route_rdy    = m_axi_wready[sel_reg];
  assign m_axi_wvalid = ((state == ROUTE) && s_axi_wvalid) ? sel_onehot : '0;
  assign m_axi_wdata  = s_axi_wdata;
  assign m_axi_wstrb  = s_axi_wstrb;
  assign m_axi_wlast  = s_axi_wlast;
`endif

endmodule

// File: tb/tb_axi_crossbar_wr_route.sv
module tb_axi_crossbar_wr_route;
  localparam int M_COUNT    = 4;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = 4;
  localparam int ID_WIDTH   = 8;
  localparam int CL         = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [CL-1:0]         s_wc_select;
  logic                  s_wc_decerr;
  logic [ID_WIDTH-1:0]   s_wc_id;
  logic                  s_wc_valid;
  logic                  s_wc_ready;
  logic [DATA_WIDTH-1:0] s_axi_wdata;
  logic [STRB_WIDTH-1:0] s_axi_wstrb;
  logic                  s_axi_wlast;
  logic                  s_axi_wvalid;
  logic                  s_axi_wready;
  logic [DATA_WIDTH-1:0] m_axi_wdata;
  logic [STRB_WIDTH-1:0] m_axi_wstrb;
  logic                  m_axi_wlast;
  logic [M_COUNT-1:0]    m_axi_wvalid;
  logic [M_COUNT-1:0]    m_axi_wready;
  logic [ID_WIDTH-1:0]   m_decerr_bid;
  logic [1:0]            m_decerr_bresp;
  logic                  m_decerr_bvalid;
  logic                  m_decerr_bready;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic cmd_rdy_seen;

  axi_crossbar_wr_route #(
    .M_COUNT(M_COUNT), .DATA_WIDTH(DATA_WIDTH), .STRB_WIDTH(STRB_WIDTH), .ID_WIDTH(ID_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_wc_select(s_wc_select), .s_wc_decerr(s_wc_decerr), .s_wc_id(s_wc_id),
    .s_wc_valid(s_wc_valid), .s_wc_ready(s_wc_ready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_decerr_bid(m_decerr_bid), .m_decerr_bresp(m_decerr_bresp),
    .m_decerr_bvalid(m_decerr_bvalid), .m_decerr_bready(m_decerr_bready)
  );

  always #5 clk = ~clk;

  // Drives one command for one cycle (called just after a rising edge, in IDLE).
  task automatic cmd_cycle(input logic [CL-1:0] sel, input logic decerr, input logic [7:0] id);
    s_wc_select = sel; s_wc_decerr = decerr; s_wc_id = id; s_wc_valid = 1'b1;
    @(negedge clk); cmd_rdy_seen = s_wc_ready;
    @(posedge clk); #1; s_wc_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; s_wc_select = '0; s_wc_decerr = 1'b0; s_wc_id = '0; s_wc_valid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b1;
    m_axi_wready = 4'hF; m_decerr_bready = 1'b0;
    #3;
    n_checks++; if (s_wc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wc_ready got=%b exp=1", s_wc_ready); end
    n_checks++; if (s_axi_wready !== 1'b0) begin n_fail++; $display("FAIL reset_wready got=%b exp=0", s_axi_wready); end
    n_checks++; if (m_axi_wvalid !== 4'b0000) begin n_fail++; $display("FAIL reset_m_wvalid got=%b exp=0000", m_axi_wvalid); end
    n_checks++; if (m_decerr_bvalid !== 1'b0) begin n_fail++; $display("FAIL reset_bvalid got=%b exp=0", m_decerr_bvalid); end
    n_checks++; if (m_decerr_bid !== 8'h00) begin n_fail++; $display("FAIL reset_bid got=%h exp=00", m_decerr_bid); end
    s_axi_wvalid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_route_basic;
    // First beat is presented with the command: it must be held in IDLE.
    s_wc_select = 2'd2; s_wc_decerr = 1'b0; s_wc_id = 8'h01; s_wc_valid = 1'b1;
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h11; s_axi_wlast = 1'b0; m_axi_wready = 4'hF;
    @(negedge clk);
    n_checks++; if (s_wc_ready !== 1'b1) begin n_fail++; $display("FAIL basic_cmd_ready got=%b exp=1", s_wc_ready); end
    n_checks++; if (s_axi_wready !== 1'b0) begin n_fail++; $display("FAIL basic_idle_hold got=%b exp=0", s_axi_wready); end
    n_checks++; if (m_axi_wvalid !== 4'b0000) begin n_fail++; $display("FAIL basic_idle_wvalid got=%b exp=0000", m_axi_wvalid); end
    @(posedge clk); #1; s_wc_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_axi_wdata = 32'(32'h11 * (i + 1)); s_axi_wlast = (i == 3);
      @(negedge clk);
      n_checks++; if (m_axi_wvalid !== 4'b0100) begin n_fail++; $display("FAIL basic_wvalid beat=%0d got=%b exp=0100", i, m_axi_wvalid); end
      n_checks++; if (m_axi_wdata !== 32'(32'h11 * (i + 1))) begin n_fail++; $display("FAIL basic_wdata beat=%0d got=%h exp=%h", i, m_axi_wdata, 32'h11 * (i + 1)); end
      n_checks++; if (m_axi_wlast !== (i == 3)) begin n_fail++; $display("FAIL basic_wlast beat=%0d got=%b", i, m_axi_wlast); end
      n_checks++; if (s_axi_wready !== 1'b1) begin n_fail++; $display("FAIL basic_wready beat=%0d got=%b exp=1", i, s_axi_wready); end
      n_checks++; if (s_wc_ready !== 1'b0) begin n_fail++; $display("FAIL basic_cmd_blocked beat=%0d got=%b exp=0", i, s_wc_ready); end
      @(posedge clk); #1;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    @(negedge clk);
    n_checks++; if (s_wc_ready !== 1'b1) begin n_fail++; $display("FAIL basic_back_idle got=%b exp=1", s_wc_ready); end
    n_checks++; if (m_axi_wvalid !== 4'b0000) begin n_fail++; $display("FAIL basic_after_wvalid got=%b exp=0000", m_axi_wvalid); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int  idx = 0;
    logic acc;
    cmd_cycle(2'd2, 1'b0, 8'h02);
    n_checks++; if (cmd_rdy_seen !== 1'b1) begin n_fail++; $display("FAIL bp_cmd got=%b exp=1", cmd_rdy_seen); end
    // Master 2 ready toggles 1,0,1,0,... over an 8-cycle window.
    for (int c = 0; c < 8; c++) begin
      m_axi_wready = (c % 2 == 0) ? 4'hF : 4'hB;
      s_axi_wvalid = (idx < 4);
      s_axi_wdata = 32'(32'h11 * (idx + 1)); s_axi_wlast = (idx == 3);
      @(negedge clk);
      if (idx < 4) begin
        n_checks++; if (s_axi_wready !== m_axi_wready[2]) begin n_fail++; $display("FAIL bp_wready c=%0d got=%b exp=%b", c, s_axi_wready, m_axi_wready[2]); end
        n_checks++; if (m_axi_wvalid !== 4'b0100) begin n_fail++; $display("FAIL bp_wvalid c=%0d got=%b exp=0100", c, m_axi_wvalid); end
        n_checks++; if (m_axi_wdata !== 32'(32'h11 * (idx + 1))) begin n_fail++; $display("FAIL bp_wdata c=%0d got=%h exp=%h", c, m_axi_wdata, 32'h11 * (idx + 1)); end
      end
      acc = s_axi_wvalid && s_axi_wready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    n_checks++; if (idx !== 4) begin n_fail++; $display("FAIL bp_beat_count got=%0d exp=4", idx); end
    m_axi_wready = 4'hF; s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    @(negedge clk);
    n_checks++; if (s_wc_ready !== 1'b1) begin n_fail++; $display("FAIL bp_back_idle got=%b exp=1", s_wc_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_decerr;
    cmd_cycle(2'd1, 1'b1, 8'h5A);
    n_checks++; if (cmd_rdy_seen !== 1'b1) begin n_fail++; $display("FAIL de_cmd got=%b exp=1", cmd_rdy_seen); end
    m_decerr_bready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_axi_wvalid = 1'b1; s_axi_wdata = 32'(32'hE0 + i); s_axi_wlast = (i == 2);
      @(negedge clk);
      n_checks++; if (s_axi_wready !== 1'b1) begin n_fail++; $display("FAIL de_sink_wready beat=%0d got=%b exp=1", i, s_axi_wready); end
      n_checks++; if (m_axi_wvalid !== 4'b0000) begin n_fail++; $display("FAIL de_sink_wvalid beat=%0d got=%b exp=0000", i, m_axi_wvalid); end
      n_checks++; if (m_decerr_bvalid !== 1'b0) begin n_fail++; $display("FAIL de_early_bvalid beat=%0d got=%b exp=0", i, m_decerr_bvalid); end
      @(posedge clk); #1;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (m_decerr_bvalid !== 1'b1) begin n_fail++; $display("FAIL de_bvalid_hold cyc=%0d got=%b exp=1", i, m_decerr_bvalid); end
      n_checks++; if (m_decerr_bid !== 8'h5A) begin n_fail++; $display("FAIL de_bid cyc=%0d got=%h exp=5a", i, m_decerr_bid); end
      n_checks++; if (m_decerr_bresp !== 2'b11) begin n_fail++; $display("FAIL de_bresp cyc=%0d got=%b exp=11", i, m_decerr_bresp); end
      n_checks++; if (s_wc_ready !== 1'b0) begin n_fail++; $display("FAIL de_cmd_blocked cyc=%0d got=%b exp=0", i, s_wc_ready); end
      @(posedge clk); #1;
    end
    m_decerr_bready = 1'b1;
    @(negedge clk);
    n_checks++; if (m_decerr_bvalid !== 1'b1) begin n_fail++; $display("FAIL de_bvalid_at_hs got=%b exp=1", m_decerr_bvalid); end
    @(posedge clk); #1; m_decerr_bready = 1'b0;
    @(negedge clk);
    n_checks++; if (m_decerr_bvalid !== 1'b0) begin n_fail++; $display("FAIL de_bvalid_clear got=%b exp=0", m_decerr_bvalid); end
    n_checks++; if (s_wc_ready !== 1'b1) begin n_fail++; $display("FAIL de_back_idle got=%b exp=1", s_wc_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    // Cycle A: command sel=0 with its single beat already waiting.
    s_wc_select = 2'd0; s_wc_decerr = 1'b0; s_wc_valid = 1'b1;
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'hA0; s_axi_wlast = 1'b1;
    @(negedge clk);
    n_checks++; if (s_wc_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_a_cmd got=%b exp=1", s_wc_ready); end
    n_checks++; if (m_axi_wvalid !== 4'b0000) begin n_fail++; $display("FAIL b2b_a_wvalid got=%b exp=0000", m_axi_wvalid); end
    @(posedge clk); #1;
    // Cycle B: beat to master 0 while the sel=3 command waits.
    s_wc_select = 2'd3;
    @(negedge clk);
    n_checks++; if (m_axi_wvalid !== 4'b0001) begin n_fail++; $display("FAIL b2b_b_wvalid got=%b exp=0001", m_axi_wvalid); end
    n_checks++; if (m_axi_wdata !== 32'hA0) begin n_fail++; $display("FAIL b2b_b_wdata got=%h exp=a0", m_axi_wdata); end
    n_checks++; if (s_wc_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_b_cmd got=%b exp=0", s_wc_ready); end
    @(posedge clk); #1;
    // Cycle C: the single IDLE gap cycle.
    s_axi_wdata = 32'hB0;
    @(negedge clk);
    n_checks++; if (s_wc_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_c_cmd got=%b exp=1", s_wc_ready); end
    n_checks++; if (m_axi_wvalid !== 4'b0000) begin n_fail++; $display("FAIL b2b_c_gap got=%b exp=0000", m_axi_wvalid); end
    @(posedge clk); #1;
    // Cycle D: beat to master 3.
    s_wc_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (m_axi_wvalid !== 4'b1000) begin n_fail++; $display("FAIL b2b_d_wvalid got=%b exp=1000", m_axi_wvalid); end
    n_checks++; if (m_axi_wdata !== 32'hB0) begin n_fail++; $display("FAIL b2b_d_wdata got=%h exp=b0", m_axi_wdata); end
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
  endtask

  task automatic test_force_term;
    int   cnt = 0;
    logic done = 1'b0;
    cmd_cycle(2'd1, 1'b0, 8'h03);
    n_checks++; if (cmd_rdy_seen !== 1'b1) begin n_fail++; $display("FAIL ft_cmd got=%b exp=1", cmd_rdy_seen); end
    s_axi_wvalid = 1'b1; s_axi_wlast = 1'b0; m_axi_wready = 4'hF;
    for (int c = 0; c < 300 && !done; c++) begin
      s_axi_wdata = 32'(c);
      @(negedge clk);
      if (s_wc_ready) done = 1'b1;
      else if (s_axi_wready) cnt++;
      @(posedge clk); #1;
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ft_terminated got=%b exp=1", done); end
    n_checks++; if (cnt !== 257) begin n_fail++; $display("FAIL ft_beats got=%0d exp=257", cnt); end
    @(negedge clk);
    n_checks++; if (s_axi_wready !== 1'b0) begin n_fail++; $display("FAIL ft_stream_held got=%b exp=0", s_axi_wready); end
    n_checks++; if (m_axi_wvalid !== 4'b0000) begin n_fail++; $display("FAIL ft_wvalid got=%b exp=0000", m_axi_wvalid); end
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0;
  endtask

  task automatic test_reset_mid;
    cmd_cycle(2'd2, 1'b0, 8'h04);
    s_axi_wvalid = 1'b1; s_axi_wlast = 1'b0; s_axi_wdata = 32'h1;
    @(posedge clk); #1;
    s_axi_wdata = 32'h2;
    #2;
    n_checks++; if (m_axi_wvalid !== 4'b0100) begin n_fail++; $display("FAIL rm_pre_wvalid got=%b exp=0100", m_axi_wvalid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (m_axi_wvalid !== 4'b0000) begin n_fail++; $display("FAIL rm_async_wvalid got=%b exp=0000", m_axi_wvalid); end
    n_checks++; if (s_axi_wready !== 1'b0) begin n_fail++; $display("FAIL rm_async_wready got=%b exp=0", s_axi_wready); end
    n_checks++; if (s_wc_ready !== 1'b1) begin n_fail++; $display("FAIL rm_async_cmd got=%b exp=1", s_wc_ready); end
    n_checks++; if (m_decerr_bvalid !== 1'b0) begin n_fail++; $display("FAIL rm_async_bvalid got=%b exp=0", m_decerr_bvalid); end
    s_axi_wvalid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cmd_cycle(2'd1, 1'b0, 8'h05);
    n_checks++; if (cmd_rdy_seen !== 1'b1) begin n_fail++; $display("FAIL rm_new_cmd got=%b exp=1", cmd_rdy_seen); end
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'hC3; s_axi_wlast = 1'b1;
    @(negedge clk);
    n_checks++; if (m_axi_wvalid !== 4'b0010) begin n_fail++; $display("FAIL rm_new_wvalid got=%b exp=0010", m_axi_wvalid); end
    n_checks++; if (m_axi_wdata !== 32'hC3) begin n_fail++; $display("FAIL rm_new_wdata got=%h exp=c3", m_axi_wdata); end
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    @(negedge clk);
    n_checks++; if (s_wc_ready !== 1'b1) begin n_fail++; $display("FAIL rm_back_idle got=%b exp=1", s_wc_ready); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_route_basic;
    test_backpressure;
    test_decerr;
    test_back_to_back;
    test_force_term;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
